// File: rtl/pe_ctrl_param.sv
// rtl/pe_ctrl_param.sv - row-stationary PE controller: SPAD loads, MAC_CYC-cycle compute pass, psum drain
// Optional drain back-pressure counter enabled by defining PE_CTRL_PERF_EN.
module pe_ctrl_param #(
  parameter int MAC_CYC    = 4,
  parameter int IF_DEPTH   = 12,
  parameter int FILT_DEPTH = 256,
  parameter int PSUM_DEPTH = 32,
  parameter int P_W        = 5,
  parameter int Q_W        = 3,
  parameter int S_W        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [P_W-1:0]                cfg_p,
  input  logic [Q_W-1:0]                cfg_q,
  input  logic [S_W-1:0]                cfg_s,
  input  logic                          load_i,
  input  logic                          load_f,
  input  logic                          start,
  input  logic                          drain_ready,
  output logic [$clog2(IF_DEPTH)-1:0]   ifmap_spad_addr,
  output logic [$clog2(FILT_DEPTH)-1:0] filt_spad_addr,
  output logic [$clog2(PSUM_DEPTH)-1:0] psum_spad_addr,
  output logic                          ifmap_spad_we,
  output logic                          filt_spad_we,
  output logic                          psum_spad_we,
  output logic                          reset_acc,
  output logic                          acc_in_psum_sel,
  output logic                          drain_valid,
  output logic                          busy,
  output logic                          compute_complete,
  output logic                          cfg_err,
  output logic [15:0]                   perf_stall_cnt
);
  localparam int IA_W = $clog2(IF_DEPTH);
  localparam int FA_W = $clog2(FILT_DEPTH);
  localparam int PA_W = $clog2(PSUM_DEPTH);
  localparam int PH_W = $clog2(MAC_CYC);
  localparam int RW   = P_W + Q_W + S_W;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IA_W-1:0] if_addr_q, if_addr, if_inc;
  logic [FA_W-1:0] f_addr_q, f_addr, f_inc;
  logic [P_W-1:0]  k_q, p_q;
  logic [RW-1:0]   r_q, rounds_m1;
  logic [PH_W-1:0] ph_q;
  logic            load_i_q, load_f_q, cfg_err_q, done_q;
  logic            start_acc, cfg_bad, start_ok, ph_last, k_last, r_last, beat;

  assign start_acc = (state == IDLE) && start && !load_i && !load_f;
  assign cfg_bad   = (cfg_p == '0) || (cfg_q == '0) || (cfg_s == '0) || (32'(cfg_p) > 32'(PSUM_DEPTH));
  assign start_ok  = start_acc && !cfg_bad;
  assign ph_last   = (ph_q == PH_W'(MAC_CYC - 1));
  assign k_last    = (k_q == p_q - P_W'(1));
  assign r_last    = (r_q == rounds_m1);
  assign beat      = (state == DRAIN) && drain_ready;
  assign if_inc    = (if_addr_q == IA_W'(IF_DEPTH - 1)) ? if_addr_q : if_addr_q + IA_W'(1);
  assign f_inc     = (f_addr_q == FA_W'(FILT_DEPTH - 1)) ? '0 : f_addr_q + FA_W'(1);

  assign busy             = (state != IDLE);
  assign ifmap_spad_addr  = if_addr;
  assign filt_spad_addr   = f_addr;
  // k doubles as the drain beat index, so it drives the psum address in both phases
  assign psum_spad_addr   = PA_W'(k_q);
  assign compute_complete = done_q;
  assign cfg_err          = cfg_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    if_addr         = if_addr_q;
    f_addr          = f_addr_q;
    ifmap_spad_we   = 1'b0;
    filt_spad_we    = 1'b0;
    psum_spad_we    = 1'b0;
    reset_acc       = 1'b0;
    acc_in_psum_sel = 1'b0;
    drain_valid     = 1'b0;
    case (state)
      IDLE: begin
        ifmap_spad_we = load_i;
        filt_spad_we  = load_f;
        reset_acc     = load_i || load_f;
        if (load_i) if_addr = load_i_q ? if_inc : '0;
        if (load_f) f_addr  = load_f_q ? f_inc : '0;
        if (start_ok) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        psum_spad_we = ph_last;
        reset_acc    = (ph_q == PH_W'(MAC_CYC - 2)) && (r_q == '0);
        if (ph_last && k_last && r_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        acc_in_psum_sel = 1'b1;
        drain_valid     = 1'b1;
        if (drain_ready && k_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_addr_q <= '0;
      f_addr_q  <= '0;
      k_q       <= '0;
      p_q       <= '0;
      r_q       <= '0;
      rounds_m1 <= '0;
      ph_q      <= '0;
      load_i_q  <= 1'b0;
      load_f_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_i_q  <= load_i;
      load_f_q  <= load_f;
      cfg_err_q <= start_acc && cfg_bad;
      done_q    <= beat && k_last;
      case (state)
        IDLE: begin
          if_addr_q <= if_addr;
          f_addr_q  <= f_addr;
          if (start_ok) begin
            p_q       <= cfg_p;
            rounds_m1 <= RW'(cfg_q) * RW'(cfg_s) - RW'(1);
            if_addr_q <= '0;
            f_addr_q  <= '0;
            k_q       <= '0;
            r_q       <= '0;
            ph_q      <= '0;
          end
        end
        COMPUTE: begin
          if (ph_last) begin
            ph_q     <= '0;
            f_addr_q <= f_inc;
            if (k_last) begin
              k_q       <= '0;
              r_q       <= r_q + RW'(1);
              if_addr_q <= if_inc;
            end else begin
              k_q <= k_q + P_W'(1);
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        DRAIN: begin
          if (drain_ready) begin
            if (k_last) begin
              k_q       <= '0;
              r_q       <= '0;
              if_addr_q <= '0;
              f_addr_q  <= '0;
            end else begin
              k_q <= k_q + P_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                 stall_q <= '0;
    else if (start_ok)                                        stall_q <= '0;
    else if ((state == DRAIN) && !drain_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end
  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_ctrl_param.sv
// tb/tb_pe_ctrl_param.sv - randomized bench for pe_ctrl_param against a cycle-index reference model
module tb_pe_ctrl_param;
  localparam int MAC = 4;
  localparam int IFD = 12;
  localparam int FD  = 256;
  localparam int PD  = 32;
`ifdef PE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] cfg_p = '0;
  logic [2:0] cfg_q = '0;
  logic [3:0] cfg_s = '0;
  logic load_i = 1'b0, load_f = 1'b0, start = 1'b0, drain_ready = 1'b0;
  logic [3:0] ifmap_spad_addr;
  logic [7:0] filt_spad_addr;
  logic [4:0] psum_spad_addr;
  logic ifmap_spad_we, filt_spad_we, psum_spad_we, reset_acc, acc_in_psum_sel;
  logic drain_valid, busy, compute_complete, cfg_err;
  logic [15:0] perf_stall_cnt;

  always #5 clk = ~clk;

  pe_ctrl_param dut (
    .clk(clk), .rst(rst), .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_s(cfg_s),
    .load_i(load_i), .load_f(load_f), .start(start), .drain_ready(drain_ready),
    .ifmap_spad_addr(ifmap_spad_addr), .filt_spad_addr(filt_spad_addr),
    .psum_spad_addr(psum_spad_addr), .ifmap_spad_we(ifmap_spad_we),
    .filt_spad_we(filt_spad_we), .psum_spad_we(psum_spad_we), .reset_acc(reset_acc),
    .acc_in_psum_sel(acc_in_psum_sel), .drain_valid(drain_valid), .busy(busy),
    .compute_complete(compute_complete), .cfg_err(cfg_err), .perf_stall_cnt(perf_stall_cnt)
  );

  int checks = 0, errors = 0, cyc = 0;
  // model: phase (0 idle, 1 compute, 2 drain), compute cycle index, drain beat, latched P and Q*S
  int m_st = 0, m_c = 0, m_b = 0, m_p = 0, m_qs = 0, m_in_i = 0, m_in_f = 0, m_stall = 0;
  bit m_done = 0, m_err = 0, m_ik = 1, m_fk = 1;
  int n_pwe, n_iwe, n_fwe, n_err, n_busy, n_cc, cc_cyc, pwe_bits, last_ia;
  int drain_cyc, comp_cyc, first_ia, first_fa, start_cyc;
  bit seen_drain;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clr_obs();
    n_pwe = 0; n_iwe = 0; n_fwe = 0; n_err = 0; n_busy = 0; n_cc = 0; cc_cyc = -1;
    pwe_bits = 0; last_ia = -1; drain_cyc = 0; comp_cyc = 0; seen_drain = 0;
    first_ia = -1; first_fa = -1;
  endtask

  task automatic check_cycle();
    int e_ia, e_fa, e_pa, stp, ph, r;
    bit e_iwe, e_fwe, e_pwe, e_ra, e_sel, e_dv, e_busy, ck_ia, ck_fa;
    e_ia = 0; e_fa = 0; e_pa = 0; e_iwe = 0; e_fwe = 0; e_pwe = 0; e_ra = 0;
    e_sel = 0; e_dv = 0; e_busy = 0; ck_ia = 1; ck_fa = 1;
    case (m_st)
      0: begin
        e_iwe = load_i; e_fwe = load_f; e_ra = load_i | load_f;
        if (load_i) e_ia = imin(m_in_i, IFD - 1); else ck_ia = m_ik;
        if (load_f) e_fa = m_in_f % FD;           else ck_fa = m_fk;
      end
      1: begin
        stp = m_c / MAC; ph = m_c % MAC; r = stp / m_p;
        e_busy = 1; e_pa = stp % m_p; e_pwe = (ph == MAC - 1); e_ra = (ph == MAC - 2) && (r == 0);
        e_ia = imin(r, IFD - 1); e_fa = stp % FD;
      end
      default: begin
        e_busy = 1; e_sel = 1; e_dv = 1; e_pa = m_b;
        e_ia = imin(m_qs, IFD - 1); e_fa = (m_p * m_qs) % FD;
      end
    endcase
    if (ck_ia) chk("ifmap_spad_addr", ifmap_spad_addr, e_ia);
    if (ck_fa) chk("filt_spad_addr", filt_spad_addr, e_fa);
    chk("psum_spad_addr", psum_spad_addr, e_pa);
    chk("ifmap_spad_we", ifmap_spad_we, e_iwe);
    chk("filt_spad_we", filt_spad_we, e_fwe);
    chk("psum_spad_we", psum_spad_we, e_pwe);
    chk("reset_acc", reset_acc, e_ra);
    chk("acc_in_psum_sel", acc_in_psum_sel, e_sel);
    chk("drain_valid", drain_valid, e_dv);
    chk("busy", busy, e_busy);
    chk("compute_complete", compute_complete, m_done);
    chk("cfg_err", cfg_err, m_err);
    chk("perf_stall_cnt", perf_stall_cnt, PERF ? m_stall : 0);
    if (psum_spad_we) begin
      if (n_pwe < 30) pwe_bits = pwe_bits | (int'(psum_spad_addr) << n_pwe);
      n_pwe++;
    end
    if (ifmap_spad_we) begin n_iwe++; last_ia = ifmap_spad_addr; end
    if (filt_spad_we) n_fwe++;
    if (cfg_err) n_err++;
    if (busy) n_busy++;
    if (busy && !drain_valid) comp_cyc++;
    if (compute_complete) begin n_cc++; cc_cyc = cyc; end
    if (drain_valid) begin
      drain_cyc++;
      if (!seen_drain) begin seen_drain = 1; first_ia = ifmap_spad_addr; first_fa = filt_spad_addr; end
    end
  endtask

  task automatic advance();
    int st0;
    st0 = m_st; m_done = 0; m_err = 0;
    case (st0)
      0: if (start && !load_i && !load_f) begin
        if (cfg_p == 0 || cfg_q == 0 || cfg_s == 0 || int'(cfg_p) > PD) m_err = 1;
        else begin
          m_st = 1; m_c = 0; m_p = cfg_p; m_qs = int'(cfg_q) * int'(cfg_s); m_stall = 0;
        end
      end
      1: begin
        m_c++;
        if (m_c == MAC * m_p * m_qs) begin m_st = 2; m_b = 0; end
      end
      default: if (drain_ready) begin
        m_b++;
        if (m_b == m_p) begin m_st = 0; m_done = 1; m_ik = 1; m_fk = 1; end
      end else if (m_stall < 65535) m_stall++;
    endcase
    if (st0 == 0 && load_i) m_ik = 0;
    if (st0 == 0 && load_f) m_fk = 0;
    m_in_i = load_i ? m_in_i + 1 : 0;
    m_in_f = load_f ? m_in_f + 1 : 0;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    advance();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; 1: random ready; 2: three stall cycles per beat, start and load_f poked
  task automatic run_pass(int mode);
    int n, d;
    n = 0; d = 0;
    while (m_st != 0 && n < 3000) begin
      if (m_st == 2) begin
        case (mode)
          0:       drain_ready = 1'b1;
          1:       drain_ready = ($urandom % 3) != 0;
          default: drain_ready = (d % 4 == 3);
        endcase
        d++;
        start = (mode == 2);
      end else begin
        drain_ready = $urandom % 2;
        start = 1'b0;
      end
      load_f = (mode == 2) && (m_st == 1) && (m_c >= 4) && (m_c < 10);
      step();
      n++;
    end
    start = 1'b0; load_f = 1'b0; drain_ready = 1'b0;
    if (m_st != 0) begin
      checks++; errors++;
      $display("FAIL pass_timeout: got state %0d expected 0 within 3000 cycles", m_st);
    end
  endtask

  task automatic do_start(int p, int q, int s);
    cfg_p = 5'(p); cfg_q = 3'(q); cfg_s = 4'(s);
    start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    clr_obs();
    #1;
    check_cycle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // 12 ifmap + 3 filt words, then P=2 Q=1 S=3
    clr_obs();
    load_i = 1'b1; repeat (12) step(); load_i = 1'b0;
    load_f = 1'b1; repeat (3) step();  load_f = 1'b0;
    step();
    do_start(2, 1, 3);
    run_pass(0);
    step();
    chk("s1_if_writes", n_iwe, 12);
    chk("s1_compute_cycles", comp_cyc, 24);
    chk("s1_psum_writes", n_pwe, 6);
    chk("s1_psum_addr_seq", pwe_bits, 42);
    chk("s1_drain_ifmap_addr", first_ia, 3);
    chk("s1_drain_filt_addr", first_fa, 6);
    chk("s1_drain_cycles", drain_cyc, 2);
    chk("s1_complete_latency", cc_cyc - start_cyc, 27);

    // ifmap address saturation
    clr_obs();
    load_i = 1'b1; repeat (15) step(); load_i = 1'b0;
    step();
    chk("s2_if_writes", n_iwe, 15);
    chk("s2_last_if_addr", last_ia, 11);

    // rejected configuration
    clr_obs();
    do_start(0, 1, 1);
    step(); step();
    chk("s3_cfg_err_pulses", n_err, 1);
    chk("s3_busy_cycles", n_busy, 0);

    // back-pressured drain with ignored start and load_f
    clr_obs();
    do_start(4, 1, 1);
    run_pass(2);
    step();
    chk("s4_drain_cycles", drain_cyc, 16);
    chk("s4_filt_we_in_pass", n_fwe, 0);
    chk("s4_complete_pulses", n_cc, 1);
    chk("s4_perf_stall", perf_stall_cnt, PERF ? 12 : 0);

    // asynchronous reset mid-compute
    clr_obs();
    do_start(3, 2, 2);
    repeat (10) step();
    #2 rst = 1'b0;
    #1;
    chk("s5_busy_in_reset", busy, 0);
    chk("s5_ifmap_addr_in_reset", ifmap_spad_addr, 0);
    chk("s5_filt_addr_in_reset", filt_spad_addr, 0);
    chk("s5_psum_addr_in_reset", psum_spad_addr, 0);
    chk("s5_psum_we_in_reset", psum_spad_we, 0);
    m_st = 0; m_c = 0; m_b = 0; m_done = 0; m_err = 0; m_ik = 1; m_fk = 1;
    m_in_i = 0; m_in_f = 0; m_stall = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    clr_obs();
    repeat (4) step();
    chk("s5_no_complete", n_cc, 0);

    // randomized passes
    for (int it = 0; it < 14; it++) begin
      int li, lf;
      li = $urandom_range(0, 14); lf = $urandom_range(0, 4);
      load_i = 1'b1; repeat (li) step(); load_i = 1'b0;
      load_f = 1'b1; repeat (lf) step(); load_f = 1'b0;
      step();
      cfg_p = 5'($urandom_range(0, 5)); cfg_q = 3'($urandom_range(0, 3)); cfg_s = 4'($urandom_range(0, 3));
      load_i = ($urandom % 5) == 0;
      start = 1'b1;
      step();
      start = 1'b0; load_i = 1'b0;
      if (m_st != 0) run_pass(1);
      step(); step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end
endmodule
